// File: rtl/cdc_tx_arbiter.sv
// rtl/cdc_tx_arbiter.sv - round-robin source scheduler feeding the slow-to-fast delay-sample synchronizer
// Optional feature macro: CDC_ARB_PRIO0_EN (requester 0 gets strict priority over the rotation).
module cdc_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DW       = 32,
    parameter int HOLD_CYC = 2,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         din,
    output logic                  din_en,
    output logic [IDW-1:0]        gnt_id,
    output logic                  busy
);

    localparam int CW = $clog2(HOLD_CYC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] last;
    logic           win_found;
    logic [IDW-1:0] win_id;
    logic           grant;

    // Pick the first valid requester after the last winner; never looks at req_data.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
`ifdef CDC_ARB_PRIO0_EN
        if (req_valid[0]) begin
            win_found = 1'b1;
            win_id    = '0;
        end
`endif
    end

    assign grant     = (state == IDLE) && en && win_found;
    assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;

    // Launch FSM: capture the winner's word, strobe once, then hold din for HOLD_CYC cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= IDW'(NUM_REQ - 1);
            din    <= '0;
            din_en <= 1'b0;
            gnt_id <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    din_en <= 1'b0;
                    if (grant) begin
                        din    <= req_data[int'(win_id)*DW +: DW];
                        din_en <= 1'b1;
                        gnt_id <= win_id;
`ifdef CDC_ARB_PRIO0_EN
                        // Priority grants to requester 0 leave the rotation untouched.
                        if (win_id != '0) begin
                            last <= win_id;
                        end
`else
                        last   <= win_id;
`endif
                        cnt    <= CW'(HOLD_CYC - 1);
                        state  <= BUSY;
                        busy   <= 1'b1;
                    end
                end
                BUSY: begin
                    din_en <= 1'b0;
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    din_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// tb/tb_cdc_tx_arbiter.sv - self-checking bench for cdc_tx_arbiter against a behavioural model
module tb_cdc_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int H   = 2;
    localparam int IDW = $clog2(N);

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              en = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic [DW-1:0]     din;
    logic              din_en;
    logic [IDW-1:0]    gnt_id;
    logic              busy;

    cdc_tx_arbiter #(.NUM_REQ(N), .DW(DW), .HOLD_CYC(H)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .din       (din),
        .din_en    (din_en),
        .gnt_id    (gnt_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: cycles of hold still owed, rotation pointer, and the last launch.
    int            m_left;
    int            m_last;
    logic [DW-1:0] m_din;
    logic          m_den;
    int            m_gnt;

    int            q_gnt[$];
    int            q_cyc[$];
    logic [DW-1:0] q_din[$];
    logic [N-1:0]  hs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_last = N - 1;
        m_din  = '0;
        m_den  = 1'b0;
        m_gnt  = 0;
    endtask

    function automatic int m_winner();
`ifdef CDC_ARB_PRIO0_EN
        if (req_valid[0]) return 0;
`endif
        for (int k = 1; k <= N; k++) begin
            if (req_valid[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int w;
        w = m_winner();
        if (m_left == 0 && en && w >= 0) return N'(1) << w;
        return '0;
    endfunction

    // One clock: inputs already applied by the caller; check ready, advance model, check registers.
    task automatic step();
        int w;
        #1;
        chk("req_ready", 64'(req_ready), 64'(m_ready()));
        hs = req_ready & req_valid;
        w  = m_winner();
        if (!rstn) begin
            model_reset();
        end else if (m_left > 0) begin
            m_left--;
            m_den = 1'b0;
        end else if (en && w >= 0) begin
            m_din  = req_data[w*DW +: DW];
            m_den  = 1'b1;
            m_gnt  = w;
`ifdef CDC_ARB_PRIO0_EN
            if (w != 0) m_last = w;
`else
            m_last = w;
`endif
            m_left = H;
        end else begin
            m_den = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("din", 64'(din), 64'(m_din));
        chk("din_en", 64'(din_en), 64'(m_den));
        chk("gnt_id", 64'(gnt_id), 64'(m_gnt));
        chk("busy", 64'(busy), 64'(m_left > 0));
        if (din_en) begin
            q_gnt.push_back(int'(gnt_id));
            q_din.push_back(din);
            q_cyc.push_back(cyc);
        end
    endtask

    task automatic clear_log();
        q_gnt.delete();
        q_din.delete();
        q_cyc.delete();
    endtask

    task automatic run_pulses(input int n, input int budget);
        int b;
        b = 0;
        while (q_gnt.size() < n && b < budget) begin
            step();
            b++;
        end
    endtask

    task automatic chk_spacing(input string name);
        for (int i = 1; i < q_cyc.size(); i++)
            chk(name, 64'(q_cyc[i] - q_cyc[i-1]), 64'(H + 1));
    endtask

    initial begin
        int exp_rr[5];
        int k;
        int b;
        int c0;
        exp_rr = '{0, 1, 2, 3, 0};
        model_reset();
        @(negedge clk);

        // Held in reset.
        for (int i = 0; i < 3; i++) step();
        chk("reset_din_lit", 64'(din), 64'h0);
        chk("reset_busy_lit", 64'(busy), 64'h0);

        // Round robin with everyone valid.
        rstn = 1'b1;
        en   = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'h1111_0000 + i;
        clear_log();
        run_pulses(5, 40);
        chk("rr_count", 64'(q_gnt.size()), 64'd5);
        for (int i = 0; i < q_gnt.size() && i < 5; i++) begin
            chk("rr_order_lit", 64'(q_gnt[i]), 64'(exp_rr[i]));
            chk("rr_data_lit", 64'(q_din[i]), 64'(32'h1111_0000 + exp_rr[i]));
        end
        chk_spacing("rr_spacing_lit");

        // Asynchronous reset in the middle of a hold.
        b = 0;
        while (!busy && b < 10) begin step(); b++; end
        chk("busy_before_reset", 64'(busy), 64'h1);
        #2 rstn = 1'b0;
        #1;
        chk("async_din_lit", 64'(din), 64'h0);
        chk("async_den_lit", 64'(din_en), 64'h0);
        chk("async_busy_lit", 64'(busy), 64'h0);
        chk("async_gnt_lit", 64'(gnt_id), 64'h0);
        model_reset();
        step();
        step();
        rstn = 1'b1;
        clear_log();
        run_pulses(1, 10);
        chk("post_reset_first", 64'(q_gnt.size() > 0 ? q_gnt[0] : -1), 64'h0);

        // Single requester 2 streaming ten words.
        req_valid = 4'b0100;
        k = 0;
        b = 0;
        clear_log();
        while (k < 10 && b < 100) begin
            req_data[2*DW +: DW] = 32'h5555_aaaa + k * 32'h4321;
            step();
            if (hs[2]) k++;
            b++;
        end
        chk("single_count", 64'(q_gnt.size()), 64'd10);
        for (int i = 0; i < q_din.size(); i++) begin
            chk("single_data_lit", 64'(q_din[i]), 64'(32'h5555_aaaa + i * 32'h4321));
            chk("single_id", 64'(q_gnt[i]), 64'd2);
        end
        chk_spacing("single_spacing_lit");

        // Enable dropped while a transfer is in flight.
        req_valid = 4'b0001;
        b = 0;
        hs = '0;
        while (!hs[0] && b < 10) begin step(); b++; end
        en = 1'b0;
        req_valid = 4'b0010;
        clear_log();
        for (int i = 0; i < 10; i++) step();
        chk("en_off_no_pulse", 64'(q_gnt.size()), 64'd0);
        en = 1'b1;
        c0 = cyc;
        run_pulses(1, 10);
        chk("en_on_id", 64'(q_gnt.size() > 0 ? q_gnt[0] : -1), 64'd1);
        chk("en_on_latency", 64'(q_cyc.size() > 0 ? q_cyc[0] - c0 : -1), 64'd1);

        // Wrap and skip: only 1 and 3, starting with last=3.
        req_valid = 4'b1000;
        b = 0;
        hs = '0;
        while (!hs[3] && b < 10) begin step(); b++; end
        req_valid = 4'b1010;
        clear_log();
        run_pulses(4, 30);
        chk("wrap_count", 64'(q_gnt.size()), 64'd4);
        for (int i = 0; i < q_gnt.size(); i++)
            chk("wrap_order_lit", 64'(q_gnt[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

`ifdef CDC_ARB_PRIO0_EN
        req_valid = 4'b0111;
        clear_log();
        run_pulses(3, 30);
        chk("prio_count", 64'(q_gnt.size()), 64'd3);
        for (int i = 0; i < q_gnt.size(); i++) chk("prio_zero_lit", 64'(q_gnt[i]), 64'd0);
        req_valid = 4'b0110;
        for (int i = 0; i < 4; i++) step();
        clear_log();
        run_pulses(3, 30);
        chk("prio_rr_count", 64'(q_gnt.size()), 64'd3);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 7) != 0);
            req_valid = N'($urandom);
            for (int j = 0; j < N; j++) req_data[j*DW +: DW] = $urandom;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
